// File: rtl/wm_cycle_sequencer.sv
// Washing-machine programme sequencer: phase FSM with per-phase cycle counter,
// wash modes, multi-pass rinse, lid pause, fault and cancel handling.
module wm_cycle_sequencer #(
    parameter int unsigned FILL_CYCLES  = 16,
    parameter int unsigned HEAT_CYCLES  = 32,
    parameter int unsigned WASH_CYCLES  = 64,
    parameter int unsigned RINSE_CYCLES = 24,
    parameter int unsigned SPIN_CYCLES  = 32,
    parameter int unsigned RINSE_PASSES = 2,
    parameter int unsigned CNT_WIDTH    = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 sig_Coin,
    input  logic                 sig_Start,
    input  logic                 sig_Lid_Closed,
    input  logic                 sig_Cancel,
    input  logic [1:0]           sig_Mode,
    input  logic                 sig_Time_Out,
    input  logic                 sig_Out_Of_Balance,
    input  logic                 sig_Motor_Failure,
    input  logic                 sig_Fault_Clear,
    output logic [2:0]           state,
    output logic                 water_Intake,
    output logic                 heater_On,
    output logic                 motor_On,
    output logic                 door_Lock,
    output logic                 coin_Return,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] phase_Count,
    output logic [3:0]           rinse_Pass
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StReady = 3'd1,
        StFill  = 3'd2,
        StHeat  = 3'd3,
        StWash  = 3'd4,
        StRinse = 3'd5,
        StSpin  = 3'd6,
        StFault = 3'd7
    } state_e;

    localparam logic [1:0] ModeCold  = 2'b01;
    localparam logic [1:0] ModeQuick = 2'b10;
    localparam logic [1:0] ModeExtra = 2'b11;

    localparam logic [CNT_WIDTH-1:0] FillLast      = CNT_WIDTH'(FILL_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] HeatLast      = CNT_WIDTH'(HEAT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] WashLast      = CNT_WIDTH'(WASH_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] WashQuickLast = CNT_WIDTH'((WASH_CYCLES >> 1) - 1);
    localparam logic [CNT_WIDTH-1:0] RinseLast     = CNT_WIDTH'(RINSE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] SpinLast      = CNT_WIDTH'(SPIN_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] RinseFillEnd  = CNT_WIDTH'(RINSE_CYCLES / 2);
    localparam logic [3:0]           PassTarget    = 4'(RINSE_PASSES);

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;
    logic [3:0]             pass_q, pass_d;
    logic [1:0]             mode_q, mode_d;
    logic                   coin_ret_q, coin_ret_d;
    logic                   done_q, done_d;

    logic                   in_phase;
    logic                   paused;
    logic                   fault_hit;
    logic                   at_last;
    logic [CNT_WIDTH-1:0]   last_cnt;
    logic [3:0]             pass_target;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            count_q    <= '0;
            pass_q     <= '0;
            mode_q     <= '0;
            coin_ret_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            pass_q     <= pass_d;
            mode_q     <= mode_d;
            coin_ret_q <= coin_ret_d;
            done_q     <= done_d;
        end
    end

    assign in_phase    = state_q inside {StFill, StHeat, StWash, StRinse, StSpin};
    assign paused      = in_phase & ~sig_Lid_Closed;
    assign pass_target = (mode_q == ModeExtra) ? PassTarget + 4'd1 : PassTarget;
    assign fault_hit   = (sig_Time_Out & (state_q inside {StFill, StHeat}))
                       | (sig_Motor_Failure & (state_q inside {StWash, StRinse, StSpin}))
                       | (sig_Out_Of_Balance & (state_q == StSpin));

    always_comb begin
        case (state_q)
            StFill:  last_cnt = FillLast;
            StHeat:  last_cnt = HeatLast;
            StWash:  last_cnt = (mode_q == ModeQuick) ? WashQuickLast : WashLast;
            StRinse: last_cnt = RinseLast;
            default: last_cnt = SpinLast;
        endcase
    end

    assign at_last = (count_q == last_cnt);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        pass_d     = pass_q;
        mode_d     = mode_q;
        coin_ret_d = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            StIdle: begin
                if (sig_Coin) state_d = StReady;
            end
            StReady: begin
                if (sig_Cancel) begin
                    state_d    = StIdle;
                    coin_ret_d = 1'b1;
                end else if (sig_Start && sig_Lid_Closed) begin
                    state_d = StFill;
                    count_d = '0;
                    mode_d  = sig_Mode;
                end
            end
            StFault: begin
                if (sig_Fault_Clear) state_d = StIdle;
            end
            default: begin
                if (fault_hit) begin
                    state_d = StFault;
                    count_d = '0;
                    pass_d  = '0;
                end else if (sig_Cancel && state_q inside {StFill, StHeat}) begin
                    state_d    = StIdle;
                    count_d    = '0;
                    coin_ret_d = 1'b1;
                end else if (sig_Cancel && state_q inside {StWash, StRinse}) begin
                    // Drain through a full spin instead of stopping with water in the drum.
                    state_d = StSpin;
                    count_d = '0;
                    pass_d  = '0;
                end else if (sig_Lid_Closed) begin
                    if (!at_last) begin
                        count_d = count_q + 1'b1;
                    end else begin
                        count_d = '0;
                        case (state_q)
                            StFill: state_d = (mode_q == ModeCold) ? StWash : StHeat;
                            StHeat: state_d = StWash;
                            StWash: begin
                                state_d = StRinse;
                                pass_d  = 4'd1;
                            end
                            StRinse: begin
                                if (pass_q < pass_target) begin
                                    pass_d = pass_q + 4'd1;
                                end else begin
                                    state_d = StSpin;
                                    pass_d  = '0;
                                end
                            end
                            default: begin
                                state_d = StIdle;
                                done_d  = 1'b1;
                            end
                        endcase
                    end
                end
            end
        endcase
    end

    always_comb begin
        state        = state_q;
        phase_Count  = count_q;
        rinse_Pass   = pass_q;
        coin_Return  = coin_ret_q;
        done         = done_q;
        door_Lock    = in_phase;
        water_Intake = ~paused & ((state_q == StFill)
                                  | ((state_q == StRinse) & (count_q < RinseFillEnd)));
        heater_On    = ~paused & (state_q == StHeat);
        motor_On     = ~paused & (state_q inside {StWash, StRinse, StSpin});
    end

endmodule

// File: tb/tb_wm_cycle_sequencer.sv
// Bench for wm_cycle_sequencer: schedule-queue reference model checked every cycle,
// directed programme scenarios with literal expectations, then randomized stimulus.
module tb_wm_cycle_sequencer;

    localparam int FILL = 4, HEAT = 3, WASH = 6, RINSE = 2, SPIN = 5, PASSES = 2;

    logic       clock, reset;
    logic       sig_Coin, sig_Start, sig_Lid_Closed, sig_Cancel;
    logic [1:0] sig_Mode;
    logic       sig_Time_Out, sig_Out_Of_Balance, sig_Motor_Failure, sig_Fault_Clear;
    logic [2:0] state;
    logic       water_Intake, heater_On, motor_On, door_Lock, coin_Return, done;
    logic [7:0] phase_Count;
    logic [3:0] rinse_Pass;

    wm_cycle_sequencer #(
        .FILL_CYCLES (FILL),
        .HEAT_CYCLES (HEAT),
        .WASH_CYCLES (WASH),
        .RINSE_CYCLES(RINSE),
        .SPIN_CYCLES (SPIN),
        .RINSE_PASSES(PASSES),
        .CNT_WIDTH   (8)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .sig_Coin          (sig_Coin),
        .sig_Start         (sig_Start),
        .sig_Lid_Closed    (sig_Lid_Closed),
        .sig_Cancel        (sig_Cancel),
        .sig_Mode          (sig_Mode),
        .sig_Time_Out      (sig_Time_Out),
        .sig_Out_Of_Balance(sig_Out_Of_Balance),
        .sig_Motor_Failure (sig_Motor_Failure),
        .sig_Fault_Clear   (sig_Fault_Clear),
        .state             (state),
        .water_Intake      (water_Intake),
        .heater_On         (heater_On),
        .motor_On          (motor_On),
        .door_Lock         (door_Lock),
        .coin_Return       (coin_Return),
        .done              (done),
        .phase_Count       (phase_Count),
        .rinse_Pass        (rinse_Pass)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Model: a programme is the list of every cycle it will spend, popped once per
    // lid-closed cycle; m_st holds 0 idle, 1 ready, 7 fault, else the head's phase.
    typedef struct {int ph; int pass; int cnt;} step_t;
    step_t sched[$];
    int    m_st = 0;
    bit    m_coin = 0, m_done = 0;

    int n_tests = 0, n_fail = 0;
    bit check_en = 0;
    int run_cycles, max_pass, heat_cycles, wash_cycles;

    task automatic add_phase(input int ph, input int pass, input int len);
        step_t s;
        for (int i = 0; i < len; i++) begin
            s.ph = ph; s.pass = pass; s.cnt = i;
            sched.push_back(s);
        end
    endtask

    task automatic build(input logic [1:0] mode);
        sched.delete();
        add_phase(2, 0, FILL);
        if (mode != 2'b01) add_phase(3, 0, HEAT);
        add_phase(4, 0, (mode == 2'b10) ? WASH / 2 : WASH);
        for (int p = 1; p <= PASSES + ((mode == 2'b11) ? 1 : 0); p++) add_phase(5, p, RINSE);
        add_phase(6, 0, SPIN);
    endtask

    task automatic model_step();
        m_coin = 0;
        m_done = 0;
        if (reset) begin
            m_st = 0;
            sched.delete();
        end else if (m_st == 0) begin
            if (sig_Coin) m_st = 1;
        end else if (m_st == 1) begin
            if (sig_Cancel) begin
                m_st = 0; m_coin = 1;
            end else if (sig_Start && sig_Lid_Closed) begin
                build(sig_Mode);
                m_st = sched[0].ph;
            end
        end else if (m_st == 7) begin
            if (sig_Fault_Clear) m_st = 0;
        end else if ((sig_Time_Out && m_st <= 3) || (sig_Motor_Failure && m_st >= 4)
                     || (sig_Out_Of_Balance && m_st == 6)) begin
            m_st = 7;
            sched.delete();
        end else if (sig_Cancel && m_st <= 3) begin
            m_st = 0; m_coin = 1;
            sched.delete();
        end else if (sig_Cancel && m_st <= 5) begin
            sched.delete();
            add_phase(6, 0, SPIN);
            m_st = 6;
        end else if (sig_Lid_Closed) begin
            void'(sched.pop_front());
            if (sched.size() == 0) begin
                m_st = 0; m_done = 1;
            end else begin
                m_st = sched[0].ph;
            end
        end
    endtask

    function automatic logic [20:0] model_vec();
        bit run;
        int cnt, ps;
        logic wat, heat, mot, lock;
        run  = (m_st >= 2 && m_st <= 6);
        cnt  = run ? sched[0].cnt : 0;
        ps   = (run && m_st == 5) ? sched[0].pass : 0;
        wat  = run && sig_Lid_Closed && (m_st == 2 || (m_st == 5 && cnt < RINSE / 2));
        heat = run && sig_Lid_Closed && m_st == 3;
        mot  = run && sig_Lid_Closed && m_st >= 4;
        lock = run;
        return {3'(m_st), wat, heat, mot, lock, m_coin, m_done, 8'(cnt), 4'(ps)};
    endfunction

    always @(negedge clock) begin
        if (check_en) begin
            n_tests++;
            if ({state, water_Intake, heater_On, motor_On, door_Lock, coin_Return, done,
                 phase_Count, rinse_Pass} !== model_vec()) begin
                n_fail++;
                $display("FAIL model_cycle t=%0t: got st=%0d w/h/m/l=%b%b%b%b coin=%b done=%b cnt=%0d pass=%0d, required vec=%h",
                         $time, state, water_Intake, heater_On, motor_On, door_Lock,
                         coin_Return, done, phase_Count, rinse_Pass, model_vec());
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic cycle();
        if (state >= 3'd2 && state <= 3'd6) run_cycles++;
        if (state == 3'd3) heat_cycles++;
        if (state == 3'd4) wash_cycles++;
        if (rinse_Pass > max_pass[3:0]) max_pass = int'(rinse_Pass);
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic quiet_inputs();
        sig_Coin = 0; sig_Start = 0; sig_Lid_Closed = 1; sig_Cancel = 0; sig_Mode = 2'b00;
        sig_Time_Out = 0; sig_Out_Of_Balance = 0; sig_Motor_Failure = 0; sig_Fault_Clear = 0;
    endtask

    task automatic start_prog(input logic [1:0] mode);
        sig_Coin = 1; cycle(); sig_Coin = 0;
        sig_Start = 1; sig_Mode = mode; cycle(); sig_Start = 0;
        chk("start_enters_fill", 32'(state), 2);
        run_cycles = 0; max_pass = 0; heat_cycles = 0; wash_cycles = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (state != 3'd0 && n < 300) begin cycle(); n++; end
        chk("wait_idle_bound", 32'(state), 0);
    endtask

    task automatic wait_for(input string name, input int st, input int cnt, input int ps);
        int n = 0;
        while (!(int'(state) == st && (cnt < 0 || int'(phase_Count) == cnt)
                 && (ps < 0 || int'(rinse_Pass) == ps)) && n < 300) begin
            cycle(); n++;
        end
        chk({"wait_", name}, 32'(state), 32'(st));
    endtask

    task automatic run_mode(input logic [1:0] mode, input int exp_len, input int exp_pass,
                            input int exp_heat, input int exp_wash);
        start_prog(mode);
        wait_idle();
        chk("prog_length", 32'(run_cycles), 32'(exp_len));
        chk("done_pulse", 32'(done), 1);
        chk("max_rinse_pass", 32'(max_pass), 32'(exp_pass));
        chk("heat_cycles", 32'(heat_cycles), 32'(exp_heat));
        chk("wash_cycles", 32'(wash_cycles), 32'(exp_wash));
        cycle();
        chk("done_one_cycle", 32'(done), 0);
    endtask

    initial begin
        quiet_inputs();
        reset = 1;
        cycle();
        check_en = 1;
        cycle();
        chk("reset_state", 32'(state), 0);
        chk("reset_count", 32'(phase_Count), 0);
        chk("reset_lock", 32'(door_Lock), 0);
        reset = 0;

        run_mode(2'b00, 22, 2, 3, 6);
        run_mode(2'b01, 19, 2, 0, 6);
        run_mode(2'b10, 19, 2, 3, 3);
        run_mode(2'b11, 24, 3, 3, 6);

        // Lid opened for 5 cycles at WASH count 2.
        start_prog(2'b00);
        wait_for("wash2", 4, 2, -1);
        sig_Lid_Closed = 0;
        #1;
        chk("pause_motor_off", 32'(motor_On), 0);
        chk("pause_lock_held", 32'(door_Lock), 1);
        for (int i = 0; i < 5; i++) cycle();
        chk("pause_count_held", 32'(phase_Count), 2);
        sig_Lid_Closed = 1;
        wait_idle();
        chk("pause_prog_length", 32'(run_cycles), 27);

        // Imbalance at SPIN count 1, then operator clear.
        start_prog(2'b00);
        wait_for("spin1", 6, 1, -1);
        sig_Out_Of_Balance = 1; cycle(); sig_Out_Of_Balance = 0;
        chk("fault_state", 32'(state), 7);
        chk("fault_enables", 32'({water_Intake, heater_On, motor_On, door_Lock}), 0);
        sig_Fault_Clear = 1; cycle(); sig_Fault_Clear = 0;
        chk("fault_clear_state", 32'(state), 0);
        chk("fault_no_coin", 32'(coin_Return), 0);

        // Cancel in READY.
        sig_Coin = 1; cycle(); sig_Coin = 0;
        sig_Cancel = 1; cycle(); sig_Cancel = 0;
        chk("cancel_ready_state", 32'(state), 0);
        chk("cancel_ready_coin", 32'(coin_Return), 1);
        cycle();
        chk("coin_one_cycle", 32'(coin_Return), 0);

        // Cancel at WASH count 3 drains through a full spin.
        start_prog(2'b00);
        wait_for("wash3", 4, 3, -1);
        sig_Cancel = 1; cycle(); sig_Cancel = 0;
        chk("cancel_wash_state", 32'(state), 6);
        chk("cancel_wash_count", 32'(phase_Count), 0);
        run_cycles = 0;
        wait_idle();
        chk("cancel_spin_len", 32'(run_cycles), 5);
        chk("cancel_spin_done", 32'(done), 1);

        // Reset in rinse pass 2.
        start_prog(2'b00);
        wait_for("rinse_p2", 5, -1, 2);
        reset = 1; cycle(); reset = 0;
        chk("rst_mid_state", 32'(state), 0);
        chk("rst_mid_pass", 32'(rinse_Pass), 0);
        chk("rst_mid_count", 32'(phase_Count), 0);
        chk("rst_mid_pulses", 32'({coin_Return, done}), 0);

        for (int i = 0; i < 4000; i++) begin
            sig_Coin           = ($urandom_range(0, 99) < 30);
            sig_Start          = ($urandom_range(0, 99) < 40);
            sig_Lid_Closed     = ($urandom_range(0, 99) < 88);
            sig_Cancel         = ($urandom_range(0, 99) < 3);
            sig_Mode           = 2'($urandom_range(0, 3));
            sig_Time_Out       = ($urandom_range(0, 99) < 2);
            sig_Motor_Failure  = ($urandom_range(0, 199) < 2);
            sig_Out_Of_Balance = ($urandom_range(0, 99) < 2);
            sig_Fault_Clear    = ($urandom_range(0, 99) < 20);
            reset              = ($urandom_range(0, 299) == 0);
            cycle();
        end
        reset = 0;
        quiet_inputs();
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
